// File: rtl/testbench_ls_pilot_gen.sv
// testbench_ls_pilot_gen
//   Avalon-MM programmable pulse generator driving the pilot signal bus that
//   feeds the pilot PIO in_port. Software programs PERIOD / WIDTH / MASK /
//   COUNT and writes START. The block emits COUNT pulses, or pulses forever
//   when COUNT is 0. Each pulse is WIDTH cycles of MASK followed by
//   (PERIOD - WIDTH) cycles of 0.
// Ports:
//   clk, reset_n        clock / async active-low reset
//   address, chipselect, write_n, writedata   Avalon slave write side
//   readdata            registered read data, 1-cycle latency, no strobe
//   pilot_out           registered pilot pulses (glitch-free)
//   busy                run in progress
// Register map (word address):
//   0 CTRL   W  bit0 START, bit1 STOP, bit2 CLR_DONE (self-clearing, reads 0)
//   1 PERIOD RW
//   2 WIDTH  RW
//   3 MASK   RW
//   4 COUNT  RW (0 = free-run)
//   5 STATUS R  bit0 busy, bit1 done, [31:8] emitted[23:0]
module testbench_ls_pilot_gen #(
  parameter int NCH = 8,
  parameter int CW  = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [2:0]     address,
  input  logic           chipselect,
  input  logic           write_n,
  input  logic [31:0]    writedata,
  output logic [31:0]    readdata,
  output logic [NCH-1:0] pilot_out,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t         state;
  logic [CW-1:0]  period, width, count;
  logic [NCH-1:0] mask;
  logic [CW-1:0]  s_period, s_width;
  logic [NCH-1:0] s_mask;
  logic [CW-1:0]  wcnt, lcnt, emitted;
  logic           done;

  logic wr, ctrl_wr, start, stop, clr_done, last_pulse;

  assign wr       = chipselect && !write_n;
  assign ctrl_wr  = wr && (address == 3'd0);
  assign start    = ctrl_wr && writedata[0];
  assign stop     = ctrl_wr && writedata[1];
  assign clr_done = ctrl_wr && writedata[2];
  assign busy     = (state != IDLE);

  // Widened compare so emitted+1 cannot wrap when emitted is saturated.
  assign last_pulse = (count != '0) &&
                      (({1'b0, emitted} + (CW+1)'(1)) == {1'b0, count});

  // A zero width still produces a one-cycle pulse.
  function automatic logic [CW-1:0] eff_w(input logic [CW-1:0] w);
    return (w == '0) ? CW'(1) : w;
  endfunction

  // Low phase never shorter than one cycle, even when width >= period.
  function automatic logic [CW-1:0] low_time(input logic [CW-1:0] p,
                                             input logic [CW-1:0] w);
    logic [CW-1:0] we;
    we = eff_w(w);
    return (p > we) ? (p - we) : CW'(1);
  endfunction

  // Live configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period <= '0;
      width  <= '0;
      mask   <= '0;
      count  <= '0;
    end else if (wr) begin
      case (address)
        3'd1:    period <= writedata[CW-1:0];
        3'd2:    width  <= writedata[CW-1:0];
        3'd3:    mask   <= writedata[NCH-1:0];
        3'd4:    count  <= writedata[CW-1:0];
        default: ;
      endcase
    end
  end

  // Pulse FSM with registered pilot_out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pilot_out <= '0;
      s_period  <= '0;
      s_width   <= '0;
      s_mask    <= '0;
      wcnt      <= '0;
      lcnt      <= '0;
      emitted   <= '0;
      done      <= 1'b0;
    end else begin
      // A later done<=1 in this block overrides the clear.
      if (clr_done) done <= 1'b0;
      if (stop) begin
        state     <= IDLE;
        pilot_out <= '0;
      end else begin
        case (state)
          IDLE: begin
            pilot_out <= '0;
            if (start) begin
              s_period  <= period;
              s_width   <= width;
              s_mask    <= mask;
              emitted   <= '0;
              done      <= 1'b0;
              wcnt      <= eff_w(width);
              pilot_out <= mask;
              state     <= HIGH;
            end
          end
          HIGH: begin
            if (wcnt == CW'(1)) begin
              lcnt      <= low_time(s_period, s_width);
              pilot_out <= '0;
              state     <= LOW;
            end else begin
              wcnt <= wcnt - CW'(1);
            end
          end
          LOW: begin
            if (lcnt == CW'(1)) begin
              if (emitted != '1) emitted <= emitted + CW'(1);
              if (last_pulse) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                // Pulse boundary: pick up any mid-run reconfiguration.
                s_period  <= period;
                s_width   <= width;
                s_mask    <= mask;
                wcnt      <= eff_w(width);
                pilot_out <= mask;
                state     <= HIGH;
              end
            end else begin
              lcnt <= lcnt - CW'(1);
            end
          end
          default: begin
            state     <= IDLE;
            pilot_out <= '0;
          end
        endcase
      end
    end
  end

  // Read mux, registered every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        3'd1:    readdata <= 32'(period);
        3'd2:    readdata <= 32'(width);
        3'd3:    readdata <= 32'(mask);
        3'd4:    readdata <= 32'(count);
        3'd5:    readdata <= {emitted[23:0], 6'd0, done, busy};
        default: readdata <= '0;
      endcase
    end
  end

endmodule
